// File: rtl/multicycle_mem_responder_pkg.sv
// Purpose: shared definitions for the multicycle memory responder (state encodings, defaults).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_mem_responder_pkg;

    // Responder FSM encodings, shared with the CPU-side control code.
    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    localparam int DEF_XLEN      = 32;
    localparam int DEF_NUM_WORDS = 1024;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_LATENCY   = 2;

    // Latency counter width; LATENCY is limited to 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/multicycle_mem_responder_array.sv
// Purpose: synchronous single-port word array with registered read, no reset on contents.
// Latency: write commits on the edge with we_i; rdata_o shows mem[idx_i] one edge after idx_i.
// Backpressure: none; accepts an access every cycle.
// Ports: clk, we_i (write enable), idx_i (word index), wdata_i (write data), rdata_o (registered read data).
module mem_word_array #(
    parameter int XLEN      = 32,
    parameter int NUM_WORDS = 1024,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [XLEN-1:0]  rdata_o
);

    logic [XLEN-1:0] mem_q [NUM_WORDS];
    logic [XLEN-1:0] rdata_q;

    // Storage is deliberately not reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/multicycle_mem_responder.sv
// Purpose: memory-side responder for the multicycle CPU; one read/write at a time, unified I/D memory.
// Latency: LATENCY edges from accept to completion; ready pulses for one cycle after that edge.
// Backpressure: busy is high in BUSY/DONE; requests are only sampled in IDLE.
// Ports: clk, reset (async high), mem_read/mem_write (request), addr (byte address), din (write data),
//        dout (last completed read), ready (completion pulse), busy, err (illegal request, with ready).
module multicycle_mem_responder
    import multicycle_mem_responder_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   din,
    output logic [XLEN-1:0]   dout,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;           // latched op: 1 = write (also for read+write)
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  din_q, din_d;
    logic             bad_addr_q, bad_addr_d; // misaligned or out of range
    logic             illegal_q, illegal_d;   // anything that raises err
    logic [XLEN-1:0]  dout_q, dout_d;

    logic             req;
    logic [IDX_W-1:0] idx_in;
    logic             bad_addr_in;
    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [XLEN-1:0]  arr_rdata;

    assign req         = mem_read | mem_write;
    assign idx_in      = addr[IDX_W+1:2];
    assign bad_addr_in = (addr[1:0] != 2'b00) ||
                         ({2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(NUM_WORDS));

    // In IDLE the array already looks up the incoming address so that the
    // registered read data is valid even for LATENCY=1; afterwards it tracks
    // the latched index, which also serves as the write index.
    assign arr_idx = (state_q == MEM_IDLE) ? idx_in : idx_q;

    mem_word_array #(
        .XLEN      (XLEN),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .idx_i   (arr_idx),
        .wdata_i (din_q),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        din_d      = din_q;
        bad_addr_d = bad_addr_q;
        illegal_d  = illegal_q;
        dout_d     = dout_q;
        arr_we     = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                if (req) begin
                    state_d    = MEM_BUSY;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    wr_d       = mem_write;
                    idx_d      = idx_in;
                    din_d      = din;
                    bad_addr_d = bad_addr_in;
                    illegal_d  = bad_addr_in | (mem_read & mem_write);
                end
            end
            MEM_BUSY: begin
                if (cnt_q == '0) begin
                    // Completion edge: commit the write or load dout.
                    state_d = MEM_DONE;
                    if (wr_q) begin
                        arr_we = ~bad_addr_q;
                    end else begin
                        dout_d = bad_addr_q ? '0 : arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= MEM_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            din_q      <= '0;
            bad_addr_q <= 1'b0;
            illegal_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            din_q      <= din_d;
            bad_addr_q <= bad_addr_d;
            illegal_q  <= illegal_d;
            dout_q     <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign ready = (state_q == MEM_DONE);
    assign err   = (state_q == MEM_DONE) & illegal_q;
    assign busy  = (state_q != MEM_IDLE);

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Purpose: scoreboard bench for multicycle_mem_responder at LATENCY=2 (dut0) and LATENCY=1 (dut1).
// Latency: expected completion cycle is accept cycle + LATENCY, checked per response.
// Backpressure: driver waits for ready before issuing the next request.
module tb_multicycle_mem_responder;

    logic        clk;
    logic        reset;
    logic        mr   [2];
    logic        mw   [2];
    logic [31:0] ad   [2];
    logic [31:0] di   [2];
    logic [31:0] dout_s [2];
    logic        rdy  [2];
    logic        bsy  [2];
    logic        er   [2];

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          d;
        logic [31:0] dout;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    multicycle_mem_responder #(
        .XLEN(32), .NUM_WORDS(1024), .ADDR_W(32), .LATENCY(2)
    ) dut0 (
        .clk(clk), .reset(reset), .mem_read(mr[0]), .mem_write(mw[0]),
        .addr(ad[0]), .din(di[0]), .dout(dout_s[0]), .ready(rdy[0]),
        .busy(bsy[0]), .err(er[0])
    );

    multicycle_mem_responder #(
        .XLEN(32), .NUM_WORDS(1024), .ADDR_W(32), .LATENCY(1)
    ) dut1 (
        .clk(clk), .reset(reset), .mem_read(mr[1]), .mem_write(mw[1]),
        .addr(ad[1]), .din(di[1]), .dout(dout_s[1]), .ready(rdy[1]),
        .busy(bsy[1]), .err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ready pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_ready: dut%0d got ready with empty scoreboard (cycle %0d)", d, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_dut",   32'(d),         32'(mon_e.d));
                    chk("resp_cycle", 32'(cyc),       32'(mon_e.cyc));
                    chk("resp_err",   32'(er[d]),     32'(mon_e.err));
                    chk("resp_dout",  dout_s[d],      mon_e.dout);
                end
            end
        end
    end

    // Present a request from just after an edge; the next edge is the accept edge.
    task automatic start(input int d, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] ed, input logic ee,
                         input bit push, output int acc);
        exp_t e;
        mr[d] = rd;
        mw[d] = wr;
        ad[d] = a;
        di[d] = w;
        if (push) begin
            e.d    = d;
            e.dout = ed;
            e.err  = ee;
            e.cyc  = cyc + 1 + lat_of(d);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        chk("accept_busy", 32'(bsy[d]), 32'd1);
    endtask

    // Wait for the ready pulse, then step to just after the DONE->IDLE edge.
    task automatic wait_done(input int d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_run++;
            n_fail++;
            $display("FAIL ready_timeout: dut%0d got no ready within 40 cycles, required one", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int d);
        mr[d] = 1'b0;
        mw[d] = 1'b0;
        ad[d] = 32'h0;
        di[d] = 32'h0;
    endtask

    task automatic op(input int d, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] w, input logic [31:0] ed, input logic ee);
        int acc;
        start(d, rd, wr, a, w, ed, ee, 1'b1, acc);
        wait_done(d);
        drop(d);
    endtask

    logic [31:0] t6_dat [8];
    int acc, acc_prev;
    logic [31:0] prev_dout;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        t6_dat[0] = 32'h0000_0001; t6_dat[1] = 32'h1111_2222;
        t6_dat[2] = 32'hFFFF_FFFF; t6_dat[3] = 32'h8000_0000;
        t6_dat[4] = 32'h0F0F_0F0F; t6_dat[5] = 32'hF0F0_F0F0;
        t6_dat[6] = 32'h7654_3210; t6_dat[7] = 32'hC001_D00D;

        reset = 1'b1;
        drop(0);
        drop(1);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(rdy[d]), 32'd0);
            chk("reset_busy",  32'(bsy[d]), 32'd0);
            chk("reset_err",   32'(er[d]),  32'd0);
            chk("reset_dout",  dout_s[d],   32'd0);
        end
        reset = 1'b0;

        // 1: reset in the middle of a write discards it.
        op(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 32'h0, 1'b0);
        op(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0);
        start(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, acc);
        reset = 1'b1;
        drop(0);
        #2;
        chk("midreset_busy",  32'(bsy[0]), 32'd0);
        chk("midreset_ready", 32'(rdy[0]), 32'd0);
        chk("midreset_dout",  dout_s[0],   32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        op(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0);

        // 2: write then read at LATENCY=2; write leaves dout alone.
        op(0, 1'b0, 1'b1, 32'h4, 32'h1234_5678, 32'h1111_1111, 1'b0);
        op(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0);

        // 3: misaligned and out-of-range reads clear dout and flag err.
        op(0, 1'b1, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1);
        op(0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0);
        op(0, 1'b1, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);

        // 4: read+write executes as write with err; illegal writes leave memory alone.
        op(0, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5, 32'h0, 1'b1);
        op(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'hA5A5_A5A5, 1'b0);
        op(0, 1'b0, 1'b1, 32'h9, 32'hFFFF_0000, 32'hA5A5_A5A5, 1'b1);
        op(0, 1'b0, 1'b1, 32'h1008, 32'h0000_0BAD, 32'hA5A5_A5A5, 1'b1);
        op(0, 1'b1, 1'b0, 32'h8, 32'h0, 32'hA5A5_A5A5, 1'b0);

        // 5: inputs changed during BUSY are ignored.
        start(0, 1'b0, 1'b1, 32'hC, 32'hCAFE_F00D, 32'hA5A5_A5A5, 1'b0, 1'b1, acc);
        mr[0] = 1'b1;
        mw[0] = 1'b0;
        ad[0] = 32'h10;
        di[0] = 32'h0;
        wait_done(0);
        drop(0);
        op(0, 1'b1, 1'b0, 32'hC, 32'h0, 32'hCAFE_F00D, 1'b0);
        op(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h1111_1111, 1'b0);
        // Request held past ready is taken again.
        start(0, 1'b1, 1'b0, 32'hC, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, acc);
        wait_done(0);
        start(0, 1'b1, 1'b0, 32'hC, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, acc);
        wait_done(0);
        drop(0);

        // 6: LATENCY=1 back-to-back write/read pairs, 3-cycle issue interval.
        prev_dout = 32'h0;
        acc_prev  = 0;
        for (int i = 0; i < 8; i++) begin
            start(1, 1'b0, 1'b1, 32'h40 + 32'(4 * i), t6_dat[i], prev_dout, 1'b0, 1'b1, acc);
            if (i > 0) chk("b2b_interval", 32'(acc - acc_prev), 32'd3);
            acc_prev = acc;
            wait_done(1);
            start(1, 1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, t6_dat[i], 1'b0, 1'b1, acc);
            chk("b2b_interval", 32'(acc - acc_prev), 32'd3);
            acc_prev = acc;
            wait_done(1);
            prev_dout = t6_dat[i];
        end
        drop(1);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
